// File: rtl/mem_resp_router.sv
// Steers the shared memory response stream into one small circular FIFO per client, keyed by tag[SRC_BIT].
// Define ROUTER_ERRCHK_EN to add per-client outstanding counters and a sticky unexpected-response flag.
module mem_resp_router #(
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 4,
  parameter int SRC_BIT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_req_fire,
  input  logic             io_req_chosen,
  input  logic             io_resp_valid,
  output logic             io_resp_ready,
  input  logic [9:0]       io_resp_bits_tag,
  input  logic [4:0]       io_resp_bits_cmd,
  input  logic [2:0]       io_resp_bits_typ,
  input  logic [63:0]      io_resp_bits_data,
  input  logic             io_resp_bits_has_data,
`ifdef ROUTER_ERRCHK_EN
  output logic             io_err_unexpected,
  output logic [CNT_W-1:0] io_outstanding_0,
  output logic [CNT_W-1:0] io_outstanding_1,
`endif
  output logic             io_out_0_valid,
  input  logic             io_out_0_ready,
  output logic [9:0]       io_out_0_bits_tag,
  output logic [4:0]       io_out_0_bits_cmd,
  output logic [2:0]       io_out_0_bits_typ,
  output logic [63:0]      io_out_0_bits_data,
  output logic             io_out_0_bits_has_data,
  output logic             io_out_1_valid,
  input  logic             io_out_1_ready,
  output logic [9:0]       io_out_1_bits_tag,
  output logic [4:0]       io_out_1_bits_cmd,
  output logic [2:0]       io_out_1_bits_typ,
  output logic [63:0]      io_out_1_bits_data,
  output logic             io_out_1_bits_has_data
);

  localparam int PLW = 83;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  logic [PLW-1:0]     payload;
  logic               dst;
  logic               acc;
  logic [1:0]         enq, deq, empty, full;
  logic [1:0][PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][CW-1:0] count_q, count_d;
  logic [PLW-1:0]     mem_q [2][DEPTH];
  logic [PLW-1:0]     mem_d [2][DEPTH];

  assign payload = {io_resp_bits_tag, io_resp_bits_cmd, io_resp_bits_typ,
                    io_resp_bits_data, io_resp_bits_has_data};

  // Ready looks only at the registered count of the addressed FIFO; a dequeue in
  // the same cycle does not free a slot until the next cycle.
  always_comb begin
    dst = io_resp_bits_tag[SRC_BIT];
    for (int n = 0; n < 2; n++) begin
      empty[n] = (count_q[n] == '0);
      full[n]  = (count_q[n] == FULL_CNT);
    end
    io_resp_ready = ~full[dst];
    acc = io_resp_valid & io_resp_ready;
    enq = {acc & dst, acc & ~dst};
    deq = ~empty & {io_out_1_ready, io_out_0_ready};
  end

  always_comb begin
    mem_d = mem_q;
    for (int n = 0; n < 2; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n] + PW'(enq[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + PW'(deq[n]);
      count_d[n]  = count_q[n] + CW'(enq[n]) - CW'(deq[n]);
      if (enq[n]) mem_d[n][wr_ptr_q[n]] = payload;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; the counts alone decide validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign io_out_0_valid = ~empty[0];
  assign io_out_1_valid = ~empty[1];
  assign {io_out_0_bits_tag, io_out_0_bits_cmd, io_out_0_bits_typ,
          io_out_0_bits_data, io_out_0_bits_has_data} = mem_q[0][rd_ptr_q[0]];
  assign {io_out_1_bits_tag, io_out_1_bits_cmd, io_out_1_bits_typ,
          io_out_1_bits_data, io_out_1_bits_has_data} = mem_q[1][rd_ptr_q[1]];

`ifdef ROUTER_ERRCHK_EN
  logic [1:0][CNT_W-1:0] outst_q, outst_d;
  logic                  err_q, err_d;
  logic [1:0]            inc;

  // A response arriving for a client with nothing outstanding flags an error and
  // leaves the counter at zero, even if a request fires for it in the same cycle.
  always_comb begin
    err_d   = err_q;
    outst_d = outst_q;
    for (int n = 0; n < 2; n++) begin
      inc[n] = io_req_fire & (io_req_chosen == 1'(n));
      if (enq[n] && outst_q[n] == '0) err_d = 1'b1;
      if (inc[n] && !enq[n] && outst_q[n] != '1)
        outst_d[n] = outst_q[n] + 1'b1;
      else if (enq[n] && !inc[n] && outst_q[n] != '0)
        outst_d[n] = outst_q[n] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign io_err_unexpected = err_q;
  assign io_outstanding_0  = outst_q[0];
  assign io_outstanding_1  = outst_q[1];
`else
  logic unused_req;
  assign unused_req = io_req_fire ^ io_req_chosen;
`endif

endmodule

// File: tb/tb_mem_resp_router.sv
// Bench for mem_resp_router: fixed vector table, error-counter sequence and a
// randomized run, all checked against a queue-based reference model.
module tb_mem_resp_router;
  localparam int DEPTH = 2, CNT_W = 4, SRC_BIT = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, io_req_fire, io_req_chosen, io_resp_valid, io_resp_ready;
  logic [9:0] io_resp_bits_tag;
  logic [4:0] io_resp_bits_cmd;
  logic [2:0] io_resp_bits_typ;
  logic [63:0] io_resp_bits_data;
  logic io_resp_bits_has_data;
  logic io_out_0_valid, io_out_0_ready, io_out_0_bits_has_data;
  logic io_out_1_valid, io_out_1_ready, io_out_1_bits_has_data;
  logic [9:0] io_out_0_bits_tag, io_out_1_bits_tag;
  logic [4:0] io_out_0_bits_cmd, io_out_1_bits_cmd;
  logic [2:0] io_out_0_bits_typ, io_out_1_bits_typ;
  logic [63:0] io_out_0_bits_data, io_out_1_bits_data;
`ifdef ROUTER_ERRCHK_EN
  logic io_err_unexpected;
  logic [CNT_W-1:0] io_outstanding_0, io_outstanding_1;
`endif

  mem_resp_router #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SRC_BIT(SRC_BIT)) dut (
    .clk(clk), .reset(reset),
    .io_req_fire(io_req_fire), .io_req_chosen(io_req_chosen),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_tag(io_resp_bits_tag), .io_resp_bits_cmd(io_resp_bits_cmd),
    .io_resp_bits_typ(io_resp_bits_typ), .io_resp_bits_data(io_resp_bits_data),
    .io_resp_bits_has_data(io_resp_bits_has_data),
`ifdef ROUTER_ERRCHK_EN
    .io_err_unexpected(io_err_unexpected),
    .io_outstanding_0(io_outstanding_0), .io_outstanding_1(io_outstanding_1),
`endif
    .io_out_0_valid(io_out_0_valid), .io_out_0_ready(io_out_0_ready),
    .io_out_0_bits_tag(io_out_0_bits_tag), .io_out_0_bits_cmd(io_out_0_bits_cmd),
    .io_out_0_bits_typ(io_out_0_bits_typ), .io_out_0_bits_data(io_out_0_bits_data),
    .io_out_0_bits_has_data(io_out_0_bits_has_data),
    .io_out_1_valid(io_out_1_valid), .io_out_1_ready(io_out_1_ready),
    .io_out_1_bits_tag(io_out_1_bits_tag), .io_out_1_bits_cmd(io_out_1_bits_cmd),
    .io_out_1_bits_typ(io_out_1_bits_typ), .io_out_1_bits_data(io_out_1_bits_data),
    .io_out_1_bits_has_data(io_out_1_bits_has_data)
  );

  typedef logic [82:0] pl_t;
  pl_t q0[$], q1[$];
  int  os_m[2];
  bit  err_m;
  int  n_vec = 0, n_err = 0;

  typedef struct {
    bit chk; bit rst; bit vld; logic [9:0] tag; logic [63:0] data;
    bit r0; bit r1; bit rdy; bit v0; bit v1;
  } vec_t;
  vec_t tbl[33];

  function automatic vec_t mk(bit chk, bit rst, bit vld, logic [9:0] tag, logic [63:0] data,
                              bit r0, bit r1, bit rdy, bit v0, bit v1);
    vec_t v;
    v.chk = chk; v.rst = rst; v.vld = vld; v.tag = tag; v.data = data;
    v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input logic [9:0] tag, input logic [63:0] data,
                       input bit r0, input bit r1, input bit fire, input bit chosen);
    reset = rst; io_resp_valid = vld; io_resp_bits_tag = tag; io_resp_bits_data = data;
    io_resp_bits_cmd = tag[4:0] ^ data[4:0];
    io_resp_bits_typ = data[7:5];
    io_resp_bits_has_data = data[8];
    io_out_0_ready = r0; io_out_1_ready = r1;
    io_req_fire = fire; io_req_chosen = chosen;
  endtask

  function automatic int qsize(bit d);
    return d ? q1.size() : q0.size();
  endfunction

  task automatic model_check();
    bit d;
    d = io_resp_bits_tag[SRC_BIT];
    chk("resp_ready", io_resp_ready, qsize(d) < DEPTH);
    chk("out0_valid", io_out_0_valid, q0.size() != 0);
    chk("out1_valid", io_out_1_valid, q1.size() != 0);
    if (q0.size() != 0)
      chk("out0_bits", {io_out_0_bits_tag, io_out_0_bits_cmd, io_out_0_bits_typ,
                        io_out_0_bits_data, io_out_0_bits_has_data}, q0[0]);
    if (q1.size() != 0)
      chk("out1_bits", {io_out_1_bits_tag, io_out_1_bits_cmd, io_out_1_bits_typ,
                        io_out_1_bits_data, io_out_1_bits_has_data}, q1[0]);
`ifdef ROUTER_ERRCHK_EN
    chk("err_unexpected", io_err_unexpected, err_m);
    chk("outstanding_0", io_outstanding_0, os_m[0]);
    chk("outstanding_1", io_outstanding_1, os_m[1]);
`endif
  endtask

  // Reference: two bounded queues plus integer counters, evaluated at each clock edge.
  task automatic model_update();
    bit d, acc, inc, dec;
    pl_t pl;
    if (reset) begin
      q0.delete(); q1.delete();
      os_m[0] = 0; os_m[1] = 0; err_m = 0;
      return;
    end
    d   = io_resp_bits_tag[SRC_BIT];
    acc = io_resp_valid && (qsize(d) < DEPTH);
    pl  = {io_resp_bits_tag, io_resp_bits_cmd, io_resp_bits_typ,
           io_resp_bits_data, io_resp_bits_has_data};
    if (q0.size() != 0 && io_out_0_ready) void'(q0.pop_front());
    if (q1.size() != 0 && io_out_1_ready) void'(q1.pop_front());
    if (acc) begin
      if (d) q1.push_back(pl);
      else   q0.push_back(pl);
    end
    for (int n = 0; n < 2; n++) begin
      inc = io_req_fire && (int'(io_req_chosen) == n);
      dec = acc && (int'(d) == n);
      if (dec && os_m[n] == 0) err_m = 1;
      if (inc && !dec && os_m[n] < (1 << CNT_W) - 1) os_m[n]++;
      else if (dec && !inc && os_m[n] > 0) os_m[n]--;
    end
  endtask

  task automatic finish_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit do_chk);
    @(negedge clk);
    if (do_chk) model_check();
    finish_cycle();
  endtask

  initial begin
    int exp_o[6];
    drive(1, 0, 10'h000, 64'h0, 0, 0, 0, 0);

    //               chk rst vld tag     data                    r0 r1 rdy v0 v1
    tbl[0]  = mk(0, 1, 0, 10'h000, 64'h0,                  0, 0, 1, 0, 0);
    tbl[1]  = mk(1, 0, 0, 10'h000, 64'h0,                  0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 1, 10'h005, 64'hDEADBEEF_00000001,  0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 10'h005, 64'h0,                  1, 0, 1, 1, 0);
    tbl[4]  = mk(1, 0, 0, 10'h200, 64'h0,                  1, 0, 1, 0, 0);
    tbl[5]  = mk(1, 0, 1, 10'h200, 64'hA1,                 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 0, 1, 10'h200, 64'hA2,                 0, 0, 1, 0, 1);
    tbl[7]  = mk(1, 0, 1, 10'h200, 64'hA3,                 0, 0, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 1, 0, 1);
    tbl[10] = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 1, 0, 0);
    tbl[11] = mk(1, 0, 1, 10'h200, 64'hB1,                 0, 0, 1, 0, 0);
    tbl[12] = mk(1, 0, 1, 10'h200, 64'hB2,                 0, 0, 1, 0, 1);
    tbl[13] = mk(1, 0, 1, 10'h200, 64'hB3,                 0, 1, 0, 0, 1);
    tbl[14] = mk(1, 0, 1, 10'h200, 64'hB3,                 0, 0, 1, 0, 1);
    tbl[15] = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 0, 0, 1);
    tbl[16] = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 1, 0, 1);
    tbl[17] = mk(1, 0, 0, 10'h200, 64'h0,                  0, 1, 1, 0, 0);
    tbl[18] = mk(1, 0, 1, 10'h001, 64'hC1,                 0, 1, 1, 0, 0);
    tbl[19] = mk(1, 0, 1, 10'h001, 64'hC2,                 0, 1, 1, 1, 0);
    tbl[20] = mk(1, 0, 1, 10'h200, 64'hD1,                 0, 1, 1, 1, 0);
    tbl[21] = mk(1, 0, 1, 10'h001, 64'hC3,                 0, 1, 0, 1, 1);
    tbl[22] = mk(1, 0, 1, 10'h200, 64'hD2,                 0, 1, 1, 1, 0);
    tbl[23] = mk(1, 0, 1, 10'h001, 64'hC3,                 0, 1, 0, 1, 1);
    tbl[24] = mk(1, 0, 0, 10'h000, 64'h0,                  1, 1, 0, 1, 0);
    tbl[25] = mk(1, 0, 0, 10'h000, 64'h0,                  1, 1, 1, 1, 0);
    tbl[26] = mk(1, 0, 0, 10'h000, 64'h0,                  1, 1, 1, 0, 0);
    tbl[27] = mk(1, 0, 1, 10'h001, 64'hE1,                 0, 0, 1, 0, 0);
    tbl[28] = mk(1, 0, 1, 10'h200, 64'hE2,                 0, 0, 1, 1, 0);
    tbl[29] = mk(1, 1, 0, 10'h200, 64'h0,                  0, 0, 1, 1, 1);
    tbl[30] = mk(1, 0, 1, 10'h200, 64'hF1,                 0, 0, 1, 0, 0);
    tbl[31] = mk(1, 0, 0, 10'h200, 64'h0,                  1, 1, 1, 0, 1);
    tbl[32] = mk(1, 0, 0, 10'h200, 64'h0,                  1, 1, 1, 0, 0);

    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].tag, tbl[i].data, tbl[i].r0, tbl[i].r1, 0, 0);
      @(negedge clk);
      if (tbl[i].chk) begin
        model_check();
        chk($sformatf("v%0d_ready", i), io_resp_ready, tbl[i].rdy);
        chk($sformatf("v%0d_valid0", i), io_out_0_valid, tbl[i].v0);
        chk($sformatf("v%0d_valid1", i), io_out_1_valid, tbl[i].v1);
      end
      finish_cycle();
    end

`ifdef ROUTER_ERRCHK_EN
    exp_o = '{1, 2, 3, 2, 1, 0};
    drive(1, 0, 10'h000, 64'h0, 1, 1, 0, 0);
    step(1);
    for (int k = 0; k < 9; k++) begin
      if (k < 3)       drive(0, 0, 10'h200, 64'h0, 1, 1, 1, 1);
      else if (k <= 6) drive(0, 1, 10'h200, 64'(k), 1, 1, 0, 0);
      else             drive(0, 0, 10'h200, 64'h0, 1, 1, 0, 0);
      @(negedge clk);
      model_check();
      if (k >= 1 && k <= 6) chk($sformatf("seq_outstanding1_%0d", k), io_outstanding_1, exp_o[k-1]);
      chk($sformatf("seq_err_%0d", k), io_err_unexpected, k >= 7);
      finish_cycle();
    end
    drive(1, 0, 10'h000, 64'h0, 1, 1, 0, 0);
    step(1);
    drive(0, 0, 10'h000, 64'h0, 1, 1, 0, 0);
    @(negedge clk);
    chk("err_after_reset", io_err_unexpected, 0);
    finish_cycle();
`endif

    for (int i = 0; i < 3000; i++) begin
      bit heavy_req;
      heavy_req = (i < 500);
      drive($urandom_range(0, 99) == 0,
            heavy_req ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0),
            10'($urandom), {$urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            heavy_req ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1),
            $urandom_range(0, 1) == 1);
      io_resp_bits_cmd = 5'($urandom);
      io_resp_bits_typ = 3'($urandom);
      io_resp_bits_has_data = 1'($urandom);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
